// File: rtl/sha256_host_if.sv
// Stream bundle between sha256_host and its message source / digest sink.
// master is the host block; slave is the environment on the other side.
interface sha256_host_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sha256_host.sv
// Host driver for simplified_sha256: loads the message into shared memory,
// kicks the hasher, waits with a timeout, then streams the 8-word digest.
module sha256_host #(
  parameter int          NUM_OF_WORDS = 20,
  parameter logic [15:0] MESSAGE_ADDR = 16'h0000,
  parameter logic [15:0] OUTPUT_ADDR  = 16'h0100,
  parameter int          TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  sha256_host_if.master host,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  output logic        mem_clk,
  output logic        mem_own,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    NW = 8'(NUM_OF_WORDS);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_LOW,
    WAIT_HIGH, READ, SEND, ERROR
  } state_e;

  state_e state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [7:0][31:0] hash_q, hash_d;
  logic        start_q, start_d;
  logic        own_q, own_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ovalid_q, ovalid_d;
  logic [31:0] odata_q, odata_d;
  logic        olast_q, olast_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        accept;
  logic [2:0]  ridx;

  assign host.in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign accept         = host.in_valid && host.in_ready;
  assign ridx           = cnt_q[2:0] - 3'd1;
  assign host.out_valid = ovalid_q;
  assign host.out_data  = odata_q;
  assign host.out_last  = olast_q;
  assign sha_start      = start_q;
  assign sha_message_addr = MESSAGE_ADDR;
  assign sha_output_addr  = OUTPUT_ADDR;
  assign mem_clk        = clk;
  assign mem_own        = own_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = busy_q;
  assign err            = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    hash_d   = hash_q;
    start_d  = 1'b0;
    own_d    = own_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    olast_d  = olast_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = MESSAGE_ADDR + {8'h00, cnt_q};
          wdata_d = host.in_data;
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_d == NW) ? START : LOAD;
        end
      end
      START: begin
        own_d   = 1'b0;
        start_d = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW, WAIT_HIGH: begin
        tcnt_d = tcnt_q + 1'b1;
        if (tcnt_d == TO) begin
          state_d = ERROR;
          err_d   = 1'b1;
          own_d   = 1'b1;
        end else if (state_q == WAIT_LOW) begin
          if (!sha_done) state_d = WAIT_HIGH;
        end else if (sha_done) begin
          state_d = READ;
          own_d   = 1'b1;
          cnt_d   = 8'd0;
          addr_d  = OUTPUT_ADDR;
        end
      end
      READ: begin
        // cnt_q counts issue slots; data for slot n-1 lands at slot n
        cnt_d = cnt_q + 8'd1;
        if (cnt_q != 8'd0) hash_d[ridx] = mem_read_data;
        if (cnt_q < 8'd7) addr_d = OUTPUT_ADDR + {8'h00, cnt_d};
        if (cnt_q == 8'd8) begin
          state_d  = SEND;
          cnt_d    = 8'd0;
          ovalid_d = 1'b1;
          odata_d  = hash_q[0];
          olast_d  = 1'b0;
        end
      end
      SEND: begin
        if (host.out_ready) begin
          if (cnt_q == 8'd7) begin
            state_d  = IDLE;
            cnt_d    = 8'd0;
            tcnt_d   = '0;
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            odata_d = hash_q[cnt_d[2:0]];
            olast_d = (cnt_d == 8'd7);
          end
        end
      end
      ERROR: begin
        err_d = 1'b1;
        own_d = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      hash_q   <= '0;
      start_q  <= 1'b0;
      own_q    <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      olast_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      hash_q   <= hash_d;
      start_q  <= start_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      olast_q  <= olast_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

endmodule
